acc_proc_core: RTL and testbench

Parametrised multi-cycle accumulator processor: program counter, instruction register, accumulator, single-port program/data RAM and its own control FSM in one block. It executes a 3-bit-opcode accumulator instruction set. It adds a valid/ready input handshake, a memory-mapped output strobe, a program-load port and run/halt control. It is the next-generation core that the board top level instantiates directly, with switches and LEDs behind `in_*`/`out_*`.

---
 rtl/acc_proc_pkg.sv | 32 +++
 rtl/acc_proc_core_ram_sp.sv | 20 ++
 rtl/acc_proc_core.sv | 132 +++++++++++++
 tb/tb_acc_proc_core.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_proc_pkg.sv
// Shared definitions for the accumulator processor: opcodes, FSM states and
// instruction field helpers.
package acc_proc_pkg;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_IN    = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALTED
    } state_t;

    // Callers zero-extend the instruction word to 32 bits and pass their widths.
    function automatic logic [2:0] opcode_of(input logic [31:0] word, input int dw);
        return word[dw-1 -: 3];
    endfunction

    function automatic logic [31:0] operand_of(input logic [31:0] word, input int aw);
        return word & ((32'd1 << aw) - 32'd1);
    endfunction

endpackage

// File: rtl/acc_proc_core_ram_sp.sv
// Single-port RAM, DW x 2^AW, synchronous write and one-cycle synchronous read.
module ram_sp #(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/acc_proc_core.sv
// Multi-cycle accumulator processor: PC, IR, accumulator, shared program/data
// RAM, valid/ready input, memory-mapped output strobe and program-load port.
module acc_proc_core
    import acc_proc_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [DW-1:0] prog_data,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic [DW-1:0] acc,
    output logic          aeq0,
    output logic          apos,
    output logic          halted
);

    state_t        state, nxt;
    logic [AW-1:0] pc;
    logic [DW-1:0] ir;
    logic [2:0]    op;
    logic [AW-1:0] operand;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] rdata;
    logic          prog_wr;

    assign op      = opcode_of(32'(ir), DW);
    assign operand = AW'(operand_of(32'(ir), AW));
    assign aeq0    = (acc == '0);
    assign apos    = ~acc[DW-1];
    assign halted  = (state == S_HALTED);
    // Loading is only possible while the FSM is not touching the RAM.
    assign prog_wr = prog_we && (state == S_IDLE || state == S_HALTED);

    ram_sp #(.DW(DW), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (rdata)
    );

    always_comb begin
        nxt       = state;
        ram_we    = 1'b0;
        ram_addr  = pc;
        ram_wdata = acc;
        in_ready  = 1'b0;
        case (state)
            S_IDLE:   if (run) nxt = S_FETCH;
            S_FETCH:  nxt = run ? S_DECODE : S_IDLE;
            S_DECODE: nxt = S_EXEC;
            S_EXEC: begin
                ram_addr = operand;
                case (op)
                    OP_LOAD, OP_ADD, OP_SUB: nxt = S_WB;
                    OP_STORE: begin
                        ram_we = 1'b1;
                        nxt    = S_FETCH;
                    end
                    OP_IN: begin
                        in_ready = 1'b1;
                        if (in_valid) nxt = S_FETCH;
                    end
                    OP_HALT: nxt = S_HALTED;
                    default: nxt = S_FETCH;
                endcase
            end
            S_WB:     nxt = S_FETCH;
            S_HALTED: if (!run) nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
        if (prog_wr) begin
            ram_we    = 1'b1;
            ram_addr  = prog_addr;
            ram_wdata = prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= '0;
            ir        <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= nxt;
            out_valid <= 1'b0;
            case (state)
                S_DECODE: begin
                    ir <= rdata;
                    pc <= pc + AW'(1);
                end
                S_EXEC: begin
                    case (op)
                        OP_STORE: if (operand == '1) begin
                            out_data  <= acc;
                            out_valid <= 1'b1;
                        end
                        OP_IN:   if (in_valid) acc <= in_data;
                        OP_JZ:   if (acc == '0) pc <= operand;
                        OP_JPOS: if (!acc[DW-1]) pc <= operand;
                        default: ;
                    endcase
                end
                S_WB: begin
                    case (op)
                        OP_LOAD: acc <= rdata;
                        OP_ADD:  acc <= acc + rdata;
                        OP_SUB:  acc <= acc - rdata;
                        default: ;
                    endcase
                end
                S_HALTED: if (!run) pc <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_proc_core.sv
// Directed bench for acc_proc_core: table of two-operand programs plus
// hand-written sequences for jumps, PC wrap, IN handshake and reset.
module tb_acc_proc_core;
    import acc_proc_pkg::*;

    localparam int DW = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [DW-1:0] prog_data = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, out_valid, aeq0, apos, halted;
    logic [DW-1:0] out_data, acc;

    acc_proc_core #(.DW(DW), .AW(AW)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .acc       (acc),
        .aeq0      (aeq0),
        .apos      (apos),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    int            cyc;
    int            pulses;
    logic [DW-1:0] outs[$];

    typedef struct {
        logic [2:0]    op;
        logic [DW-1:0] m5;
        logic [DW-1:0] m6;
        logic [DW-1:0] exp_acc;
        logic          exp_aeq0;
        logic          exp_apos;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] ins(input logic [2:0] op, input logic [AW-1:0] a);
        return {op, a};
    endfunction

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Raise run and count edges until HALTED, logging out_valid pulses.
    task automatic go(input int budget);
        @(negedge clk);
        run = 1'b1;
        cyc = 0; pulses = 0; outs.delete();
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (out_valid) begin
                pulses++;
                outs.push_back(out_data);
            end
            if (halted) break;
        end
        chk("halt_reached", 32'(halted), 32'd1);
    endtask

    task automatic stop();
        @(negedge clk);
        run = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_stop", 32'(halted), 32'd0);
    endtask

    task automatic wait_ready(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk("in_ready_seen", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{OP_ADD,  8'h12, 8'h34, 8'h46, 1'b0, 1'b1};
        tbl[1] = '{OP_SUB,  8'h03, 8'h05, 8'hFE, 1'b0, 1'b0};
        tbl[2] = '{OP_SUB,  8'hFE, 8'hFE, 8'h00, 1'b1, 1'b1};
        tbl[3] = '{OP_ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        tbl[4] = '{OP_LOAD, 8'h11, 8'h80, 8'h80, 1'b0, 1'b0};
        tbl[5] = '{OP_SUB,  8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};

        // Reset state
        #2;
        chk("rst_acc", 32'(acc), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_aeq0", 32'(aeq0), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: LOAD 5; <op> 6; STORE 31; HALT. 14 cycles FETCH->HALTED, +1 edge from IDLE.
        for (int v = 0; v < 6; v++) begin
            load(5'd0, ins(OP_LOAD, 5'd5));
            load(5'd1, ins(tbl[v].op, 5'd6));
            load(5'd2, ins(OP_STORE, 5'd31));
            load(5'd3, ins(OP_HALT, 5'd0));
            load(5'd5, tbl[v].m5);
            load(5'd6, tbl[v].m6);
            go(40);
            chk($sformatf("v%0d_cycles", v), 32'(cyc), 32'd15);
            chk($sformatf("v%0d_pulses", v), 32'(pulses), 32'd1);
            chk($sformatf("v%0d_out_data", v), 32'(out_data), 32'(tbl[v].exp_acc));
            chk($sformatf("v%0d_acc", v), 32'(acc), 32'(tbl[v].exp_acc));
            chk($sformatf("v%0d_aeq0", v), 32'(aeq0), 32'(tbl[v].exp_aeq0));
            chk($sformatf("v%0d_apos", v), 32'(apos), 32'(tbl[v].exp_apos));
            stop();
        end

        // Conditional jumps: FE is negative and nonzero, then zero after SUB FE.
        load(5'd0,  ins(OP_LOAD, 5'd20));
        load(5'd1,  ins(OP_SUB, 5'd21));
        load(5'd2,  ins(OP_JPOS, 5'd9));
        load(5'd3,  ins(OP_JZ, 5'd9));
        load(5'd4,  ins(OP_STORE, 5'd31));
        load(5'd5,  ins(OP_SUB, 5'd22));
        load(5'd6,  ins(OP_JZ, 5'd10));
        load(5'd7,  ins(OP_HALT, 5'd0));
        load(5'd9,  ins(OP_HALT, 5'd0));
        load(5'd10, ins(OP_LOAD, 5'd23));
        load(5'd11, ins(OP_STORE, 5'd31));
        load(5'd12, ins(OP_HALT, 5'd0));
        load(5'd20, 8'h03);
        load(5'd21, 8'h05);
        load(5'd22, 8'hFE);
        load(5'd23, 8'h5A);
        go(80);
        chk("jmp_cycles", 32'(cyc), 32'd35);
        chk("jmp_pulses", 32'(pulses), 32'd2);
        chk("jmp_out0", 32'(outs.size() > 0 ? outs[0] : 8'h00), 32'h0FE);
        chk("jmp_out1", 32'(outs.size() > 1 ? outs[1] : 8'h00), 32'h05A);
        chk("jmp_acc", 32'(acc), 32'h05A);
        stop();

        // PC wrap: JZ at 31 not taken must fetch address 0 next.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        load(5'd0,  ins(OP_JZ, 5'd28));
        load(5'd1,  ins(OP_HALT, 5'd0));
        load(5'd5,  ins(OP_ADD, 5'd21));
        load(5'd6,  ins(OP_HALT, 5'd0));
        load(5'd21, 8'h07);
        load(5'd28, ins(OP_ADD, 5'd21));
        load(5'd29, ins(OP_ADD, 5'd21));
        load(5'd30, ins(OP_ADD, 5'd21));
        load(5'd31, ins(OP_JZ, 5'd5));
        go(60);
        chk("wrap_cycles", 32'(cyc), 32'd25);
        chk("wrap_acc", 32'(acc), 32'h15);
        stop();

        // IN handshake with three idle cycles; a prog_we mid-run must be ignored.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        load(5'd0, ins(OP_IN, 5'd0));
        load(5'd1, ins(OP_STORE, 5'd31));
        load(5'd2, ins(OP_HALT, 5'd0));
        @(negedge clk); run = 1'b1;
        wait_ready(10);
        @(negedge clk);
        chk("in_ready_c2", 32'(in_ready), 32'd1);
        prog_we = 1'b1; prog_addr = 5'd1; prog_data = ins(OP_HALT, 5'd0);
        @(negedge clk);
        prog_we = 1'b0;
        chk("in_ready_c3", 32'(in_ready), 32'd1);
        chk("in_acc_held", 32'(acc), 32'd0);
        @(negedge clk);
        chk("in_ready_c4", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 8'hA5;
        @(posedge clk); #1;
        chk("in_acc", 32'(acc), 32'hA5);
        chk("in_ready_drop", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        go(40);
        chk("in_pulses", 32'(pulses), 32'd1);
        chk("in_out_data", 32'(out_data), 32'hA5);
        stop();

        // Reset during IN wait
        @(negedge clk); run = 1'b1;
        wait_ready(10);
        rst_n = 1'b0;
        #1;
        chk("rin_in_ready", 32'(in_ready), 32'd0);
        chk("rin_acc", 32'(acc), 32'd0);
        chk("rin_out_data", 32'(out_data), 32'd0);
        chk("rin_halted", 32'(halted), 32'd0);
        run = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rin_state", 32'(u_dut.state), 32'(S_IDLE));

        // Reset during WB; RAM survives so a rerun without reload works.
        load(5'd0, ins(OP_LOAD, 5'd20));
        load(5'd1, ins(OP_LOAD, 5'd21));
        load(5'd2, ins(OP_STORE, 5'd31));
        load(5'd3, ins(OP_HALT, 5'd0));
        load(5'd20, 8'h3C);
        load(5'd21, 8'h99);
        @(negedge clk); run = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("rwb_state", 32'(u_dut.state), 32'(S_WB));
        chk("rwb_acc_before", 32'(acc), 32'h3C);
        rst_n = 1'b0;
        #1;
        chk("rwb_acc", 32'(acc), 32'd0);
        chk("rwb_out_valid", 32'(out_valid), 32'd0);
        chk("rwb_halted", 32'(halted), 32'd0);
        run = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        go(40);
        chk("rwb_cycles", 32'(cyc), 32'd15);
        chk("rwb_rerun_acc", 32'(acc), 32'h99);
        chk("rwb_rerun_out", 32'(out_data), 32'h99);
        stop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
